mux8_rr_arbiter: RTL and testbench

Round-robin arbiter and select controller for the 8:1 one-bit multiplexer datapath. Eight requesters compete for the shared output line. The arbiter grants one requester at a time, drives the 3-bit select, and registers the selected data bit. Ownership is bounded by a hold timeout so no requester can starve the others.

---
 rtl/mux8_rr_arbiter.sv | 118 +++++++++++
 tb/tb_mux8_rr_arbiter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter and select controller for an 8:1 one-bit mux.
// One owner at a time, bounded by a HOLD_MAX-cycle hold timeout.
module mux8_rr_arbiter #(
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic [7:0] i,
    output logic [2:0] sel,
    output logic [7:0] gnt,
    output logic       busy,
    output logic       y,
    output logic       timeout
);

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    localparam logic [4:0] HOLD_LAST = 5'(HOLD_MAX - 1);

    state_t     state, state_nxt;
    logic [2:0] last, last_nxt;
    logic [2:0] sel_nxt;
    logic [7:0] gnt_nxt;
    logic       y_nxt;
    logic       timeout_nxt;
    logic [4:0] hold_cnt, hold_nxt;

    logic       found;
    logic [2:0] win;
    logic       rel_vol;
    logic       rel_hold;

    // Scan from last+1 upward; 3-bit index arithmetic provides the wrap-around.
    always_comb begin
        found = 1'b0;
        win   = last;
        for (int k = 1; k <= 8; k++) begin
            logic [2:0] idx;
            idx = last + k[2:0];
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign rel_vol  = !req[sel];
    assign rel_hold = (hold_cnt == HOLD_LAST);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_nxt   = state;
        sel_nxt     = sel;
        gnt_nxt     = gnt;
        last_nxt    = last;
        hold_nxt    = hold_cnt;
        y_nxt       = 1'b0;
        timeout_nxt = 1'b0;

        case (state)
            ST_IDLE: begin
                gnt_nxt  = '0;
                hold_nxt = '0;
                if (found) begin
                    state_nxt = ST_BUSY;
                    sel_nxt   = win;
                    gnt_nxt   = 8'b1 << win;
                end
            end
            ST_BUSY: begin
                if (rel_vol || rel_hold) begin
                    state_nxt   = ST_IDLE;
                    gnt_nxt     = '0;
                    last_nxt    = sel;
                    hold_nxt    = '0;
                    // A simultaneous voluntary release wins over the timeout.
                    timeout_nxt = rel_hold && !rel_vol;
                end else begin
                    y_nxt    = i[sel];
                    hold_nxt = hold_cnt + 5'd1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                gnt_nxt   = '0;
                hold_nxt  = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            sel      <= 3'd0;
            gnt      <= 8'd0;
            y        <= 1'b0;
            timeout  <= 1'b0;
            last     <= 3'd7;
            hold_cnt <= 5'd0;
        end else begin
            state    <= state_nxt;
            sel      <= sel_nxt;
            gnt      <= gnt_nxt;
            y        <= y_nxt;
            timeout  <= timeout_nxt;
            last     <= last_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    assign busy = (state == ST_BUSY);

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed bench for mux8_rr_arbiter: one instance with HOLD_MAX=16 and one
// with HOLD_MAX=2, sharing clock, reset and inputs.
module tb_mux8_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] i;

    logic [2:0] sel_a, sel_b;
    logic [7:0] gnt_a, gnt_b;
    logic       busy_a, busy_b, y_a, y_b, to_a, to_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mux8_rr_arbiter #(.HOLD_MAX(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req), .i(i),
        .sel(sel_a), .gnt(gnt_a), .busy(busy_a), .y(y_a), .timeout(to_a)
    );

    mux8_rr_arbiter #(.HOLD_MAX(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req), .i(i),
        .sel(sel_b), .gnt(gnt_b), .busy(busy_b), .y(y_b), .timeout(to_b)
    );

    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t", tag, act, exp, $time);
        end
    endtask

    // Advance one rising edge; outputs are then sampled and inputs driven 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 8'h00;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [4:0] i3_tab;
        int k, ph;

        rst_n = 1'b0;
        req   = 8'h00;
        i     = 8'h00;

        // Reset and idle with no requests.
        do_reset();
        for (int n = 0; n < 10; n++) begin
            tick();
            check("idle_a_gnt", gnt_a, 8'h00);
            check("idle_a_misc", {3'b0, busy_a, y_a, to_a, 2'b0}, 8'h00);
            check("idle_a_sel", 8'(sel_a), 8'h00);
        end
        check("idle_b_gnt", gnt_b, 8'h00);

        // Single requester 3; i[3] pattern applied before edges 1..4.
        i3_tab = 5'b01101;  // bit n = i[3] before edge n
        for (int n = 0; n < 6; n++) begin
            req = (n < 5) ? 8'h08 : 8'h00;
            i   = {4'b0, i3_tab[n], 3'b0};
            tick();
            check("single_gnt", gnt_a, (n < 5) ? 8'h08 : 8'h00);
            check("single_sel", 8'(sel_a), 8'h03);
            check("single_busy", 8'(busy_a), (n < 5) ? 8'h01 : 8'h00);
            check("single_y", 8'(y_a), (n >= 1 && n < 5) ? 8'(i3_tab[n]) : 8'h00);
            check("single_to", 8'(to_a), 8'h00);
        end

        // Hold timeout on HOLD_MAX=16 with requester 0 always requesting.
        req = 8'h01;
        i   = 8'h01;
        for (int n = 0; n < 16; n++) begin
            tick();
            check("hold_gnt", gnt_a, 8'h01);
            check("hold_y", 8'(y_a), (n == 0) ? 8'h00 : 8'h01);
            check("hold_to", 8'(to_a), 8'h00);
        end
        tick();
        check("hold_rel_gnt", gnt_a, 8'h00);
        check("hold_rel_to", 8'(to_a), 8'h01);
        check("hold_rel_y", 8'(y_a), 8'h00);
        tick();
        check("hold_regrant", gnt_a, 8'h01);
        check("hold_to_clear", 8'(to_a), 8'h00);

        // Full rotation on HOLD_MAX=2: grant 2 cycles, then 1 idle cycle with timeout.
        do_reset();
        req = 8'hFF;
        for (int n = 0; n < 27; n++) begin
            k  = (n / 3) % 8;
            ph = n % 3;
            tick();
            check("rot_gnt", gnt_b, (ph < 2) ? (8'h01 << k) : 8'h00);
            check("rot_sel", 8'(sel_b), 8'(k));
            check("rot_to", 8'(to_b), (ph == 2) ? 8'h01 : 8'h00);
        end

        // Wrap priority: after 6 releases, 0 beats 6.
        do_reset();
        req = 8'h40;
        tick();
        check("wrap_g6", gnt_a, 8'h40);
        req = 8'h00;
        tick();
        check("wrap_rel6", gnt_a, 8'h00);
        req = 8'h41;
        tick();
        check("wrap_g0", gnt_a, 8'h01);
        req = 8'h40;
        tick();
        check("wrap_rel0", gnt_a, 8'h00);
        tick();
        check("wrap_g6_again", gnt_a, 8'h40);
        check("wrap_sel6", 8'(sel_a), 8'h06);

        // Reset in the middle of a grant to requester 5.
        do_reset();
        req = 8'h20;
        i   = 8'hFF;
        tick();
        check("mid_g5", gnt_a, 8'h20);
        tick();
        check("mid_y", 8'(y_a), 8'h01);
        rst_n = 1'b0;
        tick();
        check("mid_rst_gnt", gnt_a, 8'h00);
        check("mid_rst_misc", {3'b0, busy_a, y_a, to_a, 2'b0}, 8'h00);
        check("mid_rst_sel", 8'(sel_a), 8'h00);
        rst_n = 1'b1;
        req   = 8'h21;
        tick();
        check("mid_after_g0", gnt_a, 8'h01);
        check("mid_after_sel", 8'(sel_a), 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
